// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - memory-stage load/store controller for an Avalon-style data bus
module memory_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read_memory,
  input  logic        memory_write_memory,
  input  logic [1:0]  memory_size_memory,
  input  logic        memory_unsigned_memory,
  input  logic [31:0] ALU_out_memory,
  input  logic [31:0] write_data_memory,
  output logic [31:0] read_data_memory,
  output logic        stall_memory,
  output logic        address_error_memory,
  output logic        bus_error_memory,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_byteenable,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  input  logic        data_waitrequest
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [TIMEOUT_WIDTH:0] TIMEOUT_LIMIT = (TIMEOUT_WIDTH + 1)'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH:0] COUNT_ONE     = {{TIMEOUT_WIDTH{1'b0}}, 1'b1};

  state_t                   state;
  logic [TIMEOUT_WIDTH-1:0] count;
  logic [TIMEOUT_WIDTH:0]   count_inc;
  logic                     req;
  logic                     misaligned;
  logic                     timeout_hit;
  logic [3:0]               be_next;
  logic [31:0]              wd_next;
  logic [7:0]               lane_byte;
  logic [15:0]              lane_half;
  logic [31:0]              load_value;

  assign req         = memory_read_memory | memory_write_memory;
  assign count_inc   = {1'b0, count} + COUNT_ONE;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_inc == TIMEOUT_LIMIT);

  always_comb begin
    misaligned = 1'b0;
    case (memory_size_memory)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ALU_out_memory[0];
      default: misaligned = |ALU_out_memory[1:0];
    endcase
  end

  // Gated by reset so an aborted access releases the pipeline immediately.
  assign address_error_memory = !reset && (state == IDLE) && req && misaligned;
  assign stall_memory = !reset && (((state == IDLE) && req && !misaligned) || (state == BUS));

  always_comb begin
    be_next = 4'b1111;
    wd_next = write_data_memory;
    case (memory_size_memory)
      2'b00: begin
        be_next = 4'b0001 << ALU_out_memory[1:0];
        wd_next = {4{write_data_memory[7:0]}};
      end
      2'b01: begin
        be_next = ALU_out_memory[1] ? 4'b1100 : 4'b0011;
        wd_next = {2{write_data_memory[15:0]}};
      end
      default: begin
        be_next = 4'b1111;
        wd_next = write_data_memory;
      end
    endcase
  end

  always_comb begin
    lane_byte = data_readdata[7:0];
    case (ALU_out_memory[1:0])
      2'd0: lane_byte = data_readdata[7:0];
      2'd1: lane_byte = data_readdata[15:8];
      2'd2: lane_byte = data_readdata[23:16];
      2'd3: lane_byte = data_readdata[31:24];
      default: lane_byte = data_readdata[7:0];
    endcase
    lane_half = ALU_out_memory[1] ? data_readdata[31:16] : data_readdata[15:0];
    case (memory_size_memory)
      2'b00:   load_value = {{24{!memory_unsigned_memory & lane_byte[7]}}, lane_byte};
      2'b01:   load_value = {{16{!memory_unsigned_memory & lane_half[15]}}, lane_half};
      default: load_value = data_readdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      read_data_memory <= '0;
      bus_error_memory <= 1'b0;
      data_address     <= '0;
      data_read        <= 1'b0;
      data_write       <= 1'b0;
      data_byteenable  <= '0;
      data_writedata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus_error_memory <= 1'b0;
          if (req && !misaligned) begin
            data_address    <= {ALU_out_memory[31:2], 2'b00};
            data_byteenable <= be_next;
            data_writedata  <= wd_next;
            // A simultaneous read and write is treated as a read.
            data_read       <= memory_read_memory;
            data_write      <= !memory_read_memory;
            state           <= BUS;
          end
        end
        BUS: begin
          if (!data_waitrequest) begin
            data_read  <= 1'b0;
            data_write <= 1'b0;
            if (data_read) read_data_memory <= load_value;
            state <= DONE;
          end else if (timeout_hit) begin
            data_read        <= 1'b0;
            data_write       <= 1'b0;
            bus_error_memory <= 1'b1;
            read_data_memory <= '0;
            state            <= DONE;
          end else begin
            count <= count_inc[TIMEOUT_WIDTH-1:0];
          end
        end
        DONE: begin
          bus_error_memory <= 1'b0;
          count            <= '0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - randomized model-checked bench for memory_access_unit
module tb_memory_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr, uns, waitreq;
  logic [1:0]  sz;
  logic [31:0] addr, wdata, rdata;
  logic [31:0] read_data_memory, data_address, data_writedata;
  logic        stall_memory, address_error_memory, bus_error_memory;
  logic        data_read, data_write;
  logic [3:0]  data_byteenable;

  memory_access_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .memory_read_memory(rd), .memory_write_memory(wr),
    .memory_size_memory(sz), .memory_unsigned_memory(uns),
    .ALU_out_memory(addr), .write_data_memory(wdata),
    .read_data_memory(read_data_memory), .stall_memory(stall_memory),
    .address_error_memory(address_error_memory), .bus_error_memory(bus_error_memory),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata),
    .data_readdata(rdata), .data_waitrequest(waitreq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_aerr, exp_berr, exp_read, exp_write, exp_busy;
  logic [31:0] exp_addr, exp_wd, rd_hold;
  logic [3:0]  exp_be;

  int          n_stall, n_bus, n_write, n_berr, n_aerr;
  logic [3:0]  seen_be;
  logic [31:0] seen_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] s, input logic [31:0] a);
    int nb = nbytes(s);
    int off = a % 4;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] r = 0;
    int nb = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((d >> (8 * (i % nb))) & 32'hFF);
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic u,
                                             input logic [31:0] a, input logic [31:0] d);
    int nb = nbytes(s);
    logic [63:0] mask, v;
    if (nb == 4) return d;
    mask = (64'd1 << (8 * nb)) - 1;
    v = ({32'd0, d} >> (8 * (a % 4))) & mask;
    if (!u && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall_memory}, {31'd0, exp_stall});
      chk("addr_err", {31'd0, address_error_memory}, {31'd0, exp_aerr});
      chk("bus_err", {31'd0, bus_error_memory}, {31'd0, exp_berr});
      chk("data_read", {31'd0, data_read}, {31'd0, exp_read});
      chk("data_write", {31'd0, data_write}, {31'd0, exp_write});
      chk("read_data", read_data_memory, rd_hold);
      if (exp_busy) begin
        chk("data_address", data_address, exp_addr);
        chk("byteenable", {28'd0, data_byteenable}, {28'd0, exp_be});
        chk("writedata", data_writedata, exp_wd);
      end
    end
  end

  task automatic set_exp(input logic st, ae, be_, r, w, busy);
    exp_stall = st; exp_aerr = ae; exp_berr = be_;
    exp_read = r; exp_write = w; exp_busy = busy;
  endtask

  task automatic step();
    @(negedge clk);
    n_stall += int'(stall_memory);
    n_bus   += int'(data_read | data_write);
    n_write += int'(data_write);
    n_berr  += int'(bus_error_memory);
    n_aerr  += int'(address_error_memory);
    if (data_read | data_write) begin
      seen_be = data_byteenable;
      seen_wd = data_writedata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    rd = 0; wr = 0; waitreq = 0;
    set_exp(0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic access(input logic r, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                        input int waits);
    int nb = nbytes(s);
    bit timeout = (waits >= TO);
    int nbus = timeout ? TO : waits + 1;
    n_stall = 0; n_bus = 0; n_write = 0; n_berr = 0; n_aerr = 0;
    seen_be = 0; seen_wd = 0;
    rd = r; wr = w; sz = s; uns = u; addr = a; wdata = d; rdata = rdat;
    waitreq = (waits > 0);
    if ((a % nb) != 0) begin
      set_exp(0, 1, 0, 0, 0, 0);
      step();
      return;
    end
    set_exp(1, 0, 0, 0, 0, 0);
    step();
    exp_addr = a & ~32'd3;
    exp_be   = model_be(s, a);
    exp_wd   = model_wd(s, d);
    for (int i = 0; i < nbus; i++) begin
      waitreq = (i < waits);
      set_exp(1, 0, 0, r, !r, 1);
      step();
    end
    waitreq = 0;
    if (timeout) rd_hold = 0;
    else if (r) rd_hold = model_load(s, u, a, rdat);
    set_exp(0, 0, timeout, 0, 0, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1; rd = 0; wr = 0; sz = 0; uns = 0; addr = 0; wdata = 0; rdata = 0; waitreq = 0;
    rd_hold = 0;
    set_exp(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_data", read_data_memory, 32'd0);
    chk("rst_stall", {31'd0, stall_memory}, 32'd0);
    chk("rst_strobes", {30'd0, data_read, data_write}, 32'd0);
    chk("rst_errs", {30'd0, address_error_memory, bus_error_memory}, 32'd0);
    chk("rst_addr", data_address, 32'd0);
    chk("rst_be_wd", {28'd0, data_byteenable} | data_writedata, 32'd0);
    reset = 0;
    chk_en = 1;
    idle_cycle();

    access(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0);
    chk("lw_data", read_data_memory, 32'hDEADBEEF);
    chk("lw_stall_cycles", n_stall, 2);
    chk("lw_be", {28'd0, seen_be}, 32'hF);
    chk("lw_bus_cycles", n_bus, 1);

    access(1, 0, 2'b00, 0, 32'h203, 0, 32'h80FF1234, 0);
    chk("lb_signed", read_data_memory, 32'hFFFFFF80);
    chk("lb_be", {28'd0, seen_be}, 32'h8);
    access(1, 0, 2'b00, 1, 32'h203, 0, 32'h80FF1234, 0);
    chk("lbu", read_data_memory, 32'h00000080);
    access(1, 0, 2'b01, 0, 32'h202, 0, 32'h80FF1234, 1);
    chk("lh_signed", read_data_memory, 32'hFFFF80FF);

    access(0, 1, 2'b01, 0, 32'h302, 32'h0000ABCD, 0, 3);
    chk("sh_write_cycles", n_write, 4);
    chk("sh_be", {28'd0, seen_be}, 32'hC);
    chk("sh_wd", seen_wd, 32'hABCDABCD);
    chk("sh_stall_cycles", n_stall, 5);
    chk("sh_keeps_read_data", read_data_memory, 32'hFFFF80FF);

    access(1, 0, 2'b10, 0, 32'h101, 0, 0, 0);
    chk("lw_mis_aerr", n_aerr, 1);
    chk("lw_mis_stall", n_stall + n_bus, 0);
    access(0, 1, 2'b01, 0, 32'h001, 32'h55, 0, 0);
    chk("sh_mis_aerr", n_aerr, 1);
    chk("sh_mis_stall", n_stall + n_bus, 0);
    idle_cycle();

    access(1, 0, 2'b10, 0, 32'h400, 0, 32'h12345678, 9);
    chk("to_bus_cycles", n_bus, 4);
    chk("to_berr", n_berr, 1);
    chk("to_read_data", read_data_memory, 32'd0);
    access(1, 0, 2'b10, 0, 32'h404, 0, 32'hCAFEF00D, 0);
    chk("after_to_data", read_data_memory, 32'hCAFEF00D);

    access(1, 1, 2'b10, 0, 32'h500, 32'hFFFFFFFF, 32'h0BADC0DE, 1);
    chk("rw_no_write", n_write, 0);
    chk("rw_data", read_data_memory, 32'h0BADC0DE);

    // Reset in the middle of a stalled bus read.
    rd = 1; wr = 0; sz = 2'b10; addr = 32'h40; rdata = 32'h11111111; waitreq = 1;
    set_exp(1, 0, 0, 0, 0, 0);
    step();
    exp_addr = 32'h40; exp_be = 4'hF; exp_wd = wdata;
    set_exp(1, 0, 0, 1, 0, 1);
    step();
    chk_en = 0;
    reset = 1;
    #1;
    chk("midrst_read", {31'd0, data_read}, 32'd0);
    chk("midrst_stall", {31'd0, stall_memory}, 32'd0);
    rd = 0; waitreq = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    rd_hold = 0;
    chk_en = 1;
    idle_cycle();
    access(1, 0, 2'b10, 0, 32'h44, 0, 32'hA5A5A5A5, 2);
    chk("postrst_data", read_data_memory, 32'hA5A5A5A5);
    chk("postrst_stall_cycles", n_stall, 4);

    for (int k = 0; k < 200; k++) begin
      int op = $urandom_range(0, 3);
      logic [1:0] s = 2'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      int x = $urandom_range(0, 9);
      int wt = (x < 4) ? x : (x < 8) ? 0 : TO + 1;
      if ($urandom_range(0, 4) != 0) a = a & ~32'(nbytes(s) - 1);
      access(op != 1, op >= 1 && op <= 2, s, 1'($urandom_range(0, 1)), a, $urandom, $urandom, wt);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
    chk_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
Memory-stage data-memory controller between the Execute/Memory and Memory/Writeback pipeline registers. It takes load/store requests from the memory stage and drives an Avalon-style data bus with waitrequest. It stalls the pipeline until each access completes and returns size-aligned, sign- or zero-extended load data for the Memory/Writeback register to capture.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUS state before abort; 0 disables timeout
TIMEOUT_WIDTH, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
memory_read_memory  in  1  load request for instruction in memory stage
memory_write_memory  in  1  store request for instruction in memory stage
memory_size_memory  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
memory_unsigned_memory  in  1  1 = zero-extend load, 0 = sign-extend
ALU_out_memory  in  32  byte address
write_data_memory  in  32  store data (low bits significant)
read_data_memory  out  32  extended load result, valid in DONE
stall_memory  out  1  freeze fetch..memory stages and Execute/Memory register
address_error_memory  out  1  one-cycle misalignment pulse
bus_error_memory  out  1  one-cycle timeout pulse
data_address  out  32  word-aligned bus address
data_read  out  1  bus read strobe
data_write  out  1  bus write strobe
data_byteenable  out  4  bus byte lanes
data_writedata  out  32  lane-replicated store data
data_readdata  in  32  bus read data
data_waitrequest  in  1  slave not ready; hold request

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. On reset: state IDLE, all outputs 0, counter 0. Reset mid-access drops data_read/data_write immediately, with no completion.
- req = memory_read_memory | memory_write_memory. If both are high, the access is a read; the write is ignored.
- misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- IDLE:
  - If req and misaligned: address_error_memory=1 for this cycle (combinational). No bus access, stall_memory=0, state stays IDLE.
  - If req and aligned: stall_memory=1 (combinational). At the edge, register the bus outputs and go to BUS.
  - If no req: all bus strobes 0.
- Bus outputs (registered on entry to BUS, held constant while in BUS):
  - data_address = {addr[31:2],2'b00}.
  - Byteenable: byte = 4'b0001<<addr[1:0]; halfword = 4'b0011 if addr[1]=0, else 4'b1100; word = 4'b1111.
  - Writedata: byte = {4{wd[7:0]}}; halfword = {2{wd[15:0]}}; word = wd.
  - Reads drive byteenable the same way.
- BUS: stall_memory=1. Counter increments each cycle that data_waitrequest=1.
  - data_waitrequest=0: drop strobes at the edge. For a read, capture readdata lane-selected and extended into read_data_memory. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES (if nonzero) while waitrequest=1: drop strobes, bus_error_memory=1 for the DONE cycle, read_data_memory=0, go to DONE.
- DONE: stall_memory=0 for exactly one cycle, so the pipeline advances and the Memory/Writeback register captures read_data_memory. Go unconditionally to IDLE and clear the counter. The request still visible this cycle is ignored.
- Load extension:
  - Byte lane = addr[1:0]: bits [8k+7:8k].
  - Halfword: bits [15:0] if addr[1]=0, else [31:16].
  - Extension uses memory_unsigned_memory.
  - Word loads are passed unchanged.
- read_data_memory holds its value outside DONE. Stores leave it unchanged.
- Minimum access: 2 stall cycles (IDLE + one BUS cycle with waitrequest=0). Each additional waitrequest cycle adds 1.
- Inputs must be held stable by the upstream register while stall_memory=1.
- Back-to-back accesses: DONE→IDLE then the next request starts the next cycle. At most one bus transaction is outstanding.

Test Plan:
1. LW addr 0x100, waitrequest=0 → data_address=0x100, byteenable=1111 for 1 cycle, stall high 2 cycles. readdata 0xDEADBEEF → read_data_memory=0xDEADBEEF in DONE.
2. LB addr 0x203, readdata 0x80FF1234 → byteenable=1000, read_data=0xFFFFFF80. Same with unsigned=1 → 0x00000080. LH addr 0x202 unsigned=0 → 0xFFFF80FF.
3. SH addr 0x302, wd 0x0000ABCD, waitrequest high 3 cycles → data_write held 4 cycles, byteenable=1100, writedata=0xABCDABCD, stall 5 cycles total, then 1-cycle DONE.
4. LW addr 0x101 → address_error pulse 1 cycle, no data_read, stall 0. SH addr 0x001 → same.
5. TIMEOUT_CYCLES=4, waitrequest stuck 1 → strobes dropped after 4 BUS cycles, bus_error pulse in DONE, read_data=0. Next request proceeds normally.
6. Assert reset during BUS with waitrequest=1 → data_read and stall go 0 asynchronously. After release, state IDLE and a new LW completes normally. Read and write both high → read issued, data_write stays 0.
